// File: rtl/crossbar_switch_allocator.sv
// crossbar_switch_allocator: per-output round-robin allocator for a 5-port (N,S,W,E,L) crossbar.
// Packets hold their input-to-output route from head to tail, with a watchdog on stuck locks.
`default_nettype none

module crossbar_switch_allocator #(
  parameter int MAX_HOLD = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  req_i,
  input  logic [14:0] dest_i,
  input  logic [4:0]  tail_i,
  output logic [14:0] sel_o,
  output logic [4:0]  enable_o,
  output logic [4:0]  out_busy_o,
  output logic [4:0]  err_o,
  output logic [4:0]  timeout_o
);

  localparam int NP = 5;
  localparam int CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t   state    [NP];
  logic [2:0]    lock_out [NP];
  logic [2:0]    ptr      [NP];
  logic [CW-1:0] hold_cnt [NP];
  logic [NP-1:0] err_q;
  logic [NP-1:0] timeout_q;

  logic [NP-1:0] locked;
  logic [NP-1:0] busy;
  logic [NP-1:0] illegal;
  logic [NP-1:0] idle_req;
  logic [NP-1:0] expire;
  logic [NP-1:0] grant_out;
  logic [NP-1:0] granted;
  logic [2:0]    winner   [NP];
  int            cand;

  always_comb begin
    locked   = '0;
    illegal  = '0;
    idle_req = '0;
    expire   = '0;
    for (int i = 0; i < NP; i++) begin
      locked[i]   = (state[i] == LOCKED);
      illegal[i]  = (dest_i[3*i +: 3] > 3'd4) || (dest_i[3*i +: 3] == 3'(i));
      idle_req[i] = !locked[i] && req_i[i] && !illegal[i];
      // Expiry fires on the locked cycle whose increment would reach MAX_HOLD.
      expire[i]   = (MAX_HOLD != 0) && (hold_cnt[i] == CW'(MAX_HOLD - 1));
    end
  end

  always_comb begin
    busy = '0;
    for (int j = 0; j < NP; j++) begin
      for (int i = 0; i < NP; i++) begin
        if (locked[i] && (lock_out[i] == 3'(j))) busy[j] = 1'b1;
      end
    end
  end

  // Busy is taken from registered state, so a freed output waits one cycle before re-arbitration.
  always_comb begin
    grant_out = '0;
    cand      = 0;
    for (int j = 0; j < NP; j++) winner[j] = 3'd0;
    for (int j = 0; j < NP; j++) begin
      for (int off = 0; off < NP; off++) begin
        cand = (int'(ptr[j]) + off) % NP;
        if (!busy[j] && !grant_out[j] && idle_req[cand] &&
            (dest_i[3*cand +: 3] == 3'(j))) begin
          grant_out[j] = 1'b1;
          winner[j]    = 3'(cand);
        end
      end
    end
  end

  always_comb begin
    granted = '0;
    for (int j = 0; j < NP; j++) begin
      for (int i = 0; i < NP; i++) begin
        if (grant_out[j] && (winner[j] == 3'(i))) granted[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NP; i++) begin
        state[i]    <= IDLE;
        lock_out[i] <= 3'd0;
        ptr[i]      <= 3'd0;
        hold_cnt[i] <= '0;
      end
      err_q     <= '0;
      timeout_q <= '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        err_q[i]     <= req_i[i] && !locked[i] && illegal[i];
        timeout_q[i] <= 1'b0;
        if (locked[i]) begin
          if (req_i[i] && tail_i[i]) begin
            state[i] <= IDLE;
          end else if (expire[i]) begin
            state[i]     <= IDLE;
            timeout_q[i] <= 1'b1;
          end
          if (hold_cnt[i] != '1) hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end else if (granted[i]) begin
          state[i]    <= LOCKED;
          lock_out[i] <= dest_i[3*i +: 3];
          hold_cnt[i] <= '0;
        end
      end
      for (int j = 0; j < NP; j++) begin
        if (grant_out[j]) ptr[j] <= (winner[j] == 3'd4) ? 3'd0 : winner[j] + 3'd1;
      end
    end
  end

  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NP; i++) begin
      sel_o[3*i +: 3] = locked[i] ? lock_out[i] : 3'd0;
    end
  end

  assign enable_o   = locked & req_i;
  assign out_busy_o = busy;
  assign err_o      = err_q;
  assign timeout_o  = timeout_q;

endmodule

`default_nettype wire

// File: doc/crossbar_switch_allocator.md
CROSSBAR_SWITCH_ALLOCATOR -- requirements
Module: crossbar_switch_allocator

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 64: the maximum number of cycles a lock may be held without a tail transfer; 0 disables the watchdog.
REQ-002 SHALL have port index order 0=N, 1=S, 2=W, 3=E, 4=L; destination and select encoding SHALL be 3'd0..3'd4 in that order.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous and active-low.
REQ-005 req_i  in  5  per-input flit valid; a flit is present this cycle.
REQ-006 dest_i  in  15  per-input destination, 3 bits per port, port k at [3k+2:3k].
REQ-007 tail_i  in  5  per-input tail marker qualifying the current flit.
REQ-008 sel_o  out  15  per-input demux select, 3 bits per port; drives the crossbar *_cs_sel_i inputs.
REQ-009 enable_o  out  5  per-input demux enable; drives the crossbar *_cs_enable_i inputs.
REQ-010 out_busy_o  out  5  per-output lock status.
REQ-011 err_o  out  5  per-input illegal-destination pulse.
REQ-012 timeout_o  out  5  per-input watchdog forced-release pulse, one cycle.

Function
REQ-013 SHALL treat dest_i[k] as illegal when it equals k (U-turn) or exceeds 4; the request SHALL be ignored and err_o[k] SHALL be high in the next cycle, for each cycle it persists.
REQ-014 SHALL keep one lock state per input: IDLE or LOCKED(out); each output is owned by at most one input.
REQ-015 Arbitration: every cycle, each free output SHALL select one of the IDLE inputs whose req_i is high and whose dest_i is that output, using a round-robin search starting at that output's pointer.
REQ-016 A winning input SHALL enter LOCKED at the next edge, and the output's pointer SHALL advance to winner+1 mod 5.
REQ-017 Pointers SHALL NOT move when there is no grant.
REQ-018 Grant latency: with the request in cycle t, enable_o SHALL go high at the earliest in cycle t+1.
REQ-019 sel_o[k] SHALL equal the locked output while LOCKED and 3'd0 while IDLE.
REQ-020 enable_o[k] SHALL be LOCKED(k) AND req_i[k], combinationally; a transfer occurs when enable_o[k] is high.
REQ-021 dest_i SHALL be ignored while LOCKED; the lock fixes the route for the whole packet.
REQ-022 Release: a transfer with tail_i[k] high SHALL return input k to IDLE and free its output at the same edge.
REQ-023 A freed output SHALL be re-arbitrated in the following cycle, giving a one-cycle bubble.
REQ-024 A single-flit packet (head is tail) SHALL lock for exactly one enable cycle.
REQ-025 req_i dropping mid-packet SHALL keep the lock; enable_o SHALL go low, which stalls the packet without losing the route.
REQ-026 Watchdog: a per-input counter SHALL clear on grant and increment each LOCKED cycle.
REQ-027 When the watchdog counter reaches MAX_HOLD without a tail transfer, the lock SHALL be force-released and timeout_o[k] SHALL pulse for one cycle.
REQ-028 The watchdog counter SHALL saturate and SHALL NOT wrap.
REQ-029 A tail transfer in the same cycle as a watchdog expiry SHALL be a normal release with no timeout_o pulse.
REQ-030 Inputs contending for different outputs SHALL all be granted in the same cycle.
REQ-031 out_busy_o[j] SHALL be high exactly while some input is LOCKED(j).

Reset
REQ-032 Assertion of rst_n_i SHALL immediately force all inputs to IDLE, all pointers to 0, all counters to 0, and sel_o, enable_o, out_busy_o, err_o and timeout_o to 0.
REQ-033 Reset mid-packet SHALL drop all locks with no timeout_o or err_o pulse.
REQ-034 Arbitration SHALL resume on the first rising edge after deassertion.

Verification
REQ-035 Single packet: N sends a 3-flit packet to E, with tail on flit 3 -> sel_o[N]=3 and enable_o[N]=1 for 3 cycles starting 1 cycle after req; out_busy_o[E] falls after the tail.
REQ-036 Contention: S, W and L all request output N continuously with 1-flit packets from pointer 0 -> grant order S, W, L, S, ..., with one bubble cycle between grants.
REQ-037 Parallel: N->S, S->N, W->E, E->L and L->W requested in the same cycle -> all five enable_o high in the next cycle.
REQ-038 Illegal destination: E requests dest 3 (itself), then dest 7 -> no grant, err_o[E]=1 in each following cycle, and no output becomes busy.
REQ-039 Watchdog: with MAX_HOLD=4, W is locked to L and no tail is sent -> a forced release after 4 cycles, a timeout_o[W] pulse, and out_busy_o[L] low.
REQ-040 Stall and reset: req drops mid-packet -> enable_o low and the lock held; rst_n_i low asynchronously mid-packet -> all outputs 0 before the next edge.
